// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op encodings and op type.
package pc_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t PC_INC    = 3'd0;
  localparam pc_op_t PC_LOAD   = 3'd1;
  localparam pc_op_t PC_BRANCH = 3'd2;
  localparam pc_op_t PC_CALL   = 3'd3;
  localparam pc_op_t PC_RET    = 3'd4;
  localparam pc_op_t PC_HOLD   = 3'd5;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. Flop storage, occupancy counter and full/empty decode.
// The caller guarantees push and pop are never requested on the same edge.
module pc_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 8,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign sp_m1  = sp - SP_W'(1);
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];
  assign full   = (sp == SP_W'(STACK_DEPTH));
  assign empty  = (sp == '0);
  // Reading while empty would index past the array for non power-of-two depths.
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy counter; guarded so it never leaves 0..STACK_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               sp <= '0;
    else if (push && !full)   sp <= sp + SP_W'(1);
    else if (pop  && !empty)  sp <= sp_m1;
  end

  // Entry storage is left unreset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, absolute load, PC-relative branch and a
// call/return stack with sticky overflow/underflow flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                DISP_W      = 8,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_en,
  input  pc_op_t                             pc_op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [DISP_W-1:0]                  disp,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               err_ovf,
  output logic                               err_unf
);

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] stk_top;
  logic              is_call, is_ret;
  logic              push, pop, ovf_evt, unf_evt;

  assign pc_plus1  = pc_out + ADDR_W'(1);
  // Signed size cast sign-extends the displacement; the add wraps mod 2^ADDR_W.
  assign pc_branch = pc_out + ADDR_W'($signed(disp));

  assign is_call = pc_en && (pc_op == PC_CALL);
  assign is_ret  = pc_en && (pc_op == PC_RET);
  assign push    = is_call && !stack_full;
  assign pop     = is_ret  && !stack_empty;
  assign ovf_evt = is_call &&  stack_full;
  assign unf_evt = is_ret  &&  stack_empty;

  pc_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .top   (stk_top),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Next-PC select; failed CALL/RET fall through to PC+1, reserved ops hold.
  always_comb begin
    pc_nxt = pc_out;
    if (pc_en) begin
      case (pc_op)
        PC_INC:    pc_nxt = pc_plus1;
        PC_LOAD:   pc_nxt = target;
        PC_BRANCH: pc_nxt = pc_branch;
        PC_CALL:   pc_nxt = stack_full  ? pc_plus1 : target;
        PC_RET:    pc_nxt = stack_empty ? pc_plus1 : stk_top;
        default:   pc_nxt = pc_out;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_out <= RESET_ADDR;
    else        pc_out <= pc_nxt;
  end

  // Sticky error flags; a new event on the clearing edge keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= ovf_evt || (err_ovf && !err_clr);
      err_unf <= unf_evt || (err_unf && !err_clr);
    end
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, the next generation of the processor's program counter. Beyond increment and absolute load, it adds PC-relative branches and a hardware call/return stack with overflow/underflow detection. It sits between the FSM (which issues `pc_en`/`pc_op`) and the memory address mux (which consumes `pc_out`). `target` is driven from the register-mux A output.

## Interface
- `ADDR_W`, 10, PC width in bits; it must be at least 2.
- `DISP_W`, 8, width of the signed relative displacement; it must be at most `ADDR_W`.
- `STACK_DEPTH`, 8, number of return-address entries; it must be at least 1.
- `RESET_ADDR`, 0, PC value after reset.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_en`  in  1  advance strobe; when low, all state holds.
- `pc_op`  in  3  operation select; sampled only while `pc_en` is high.
- `target`  in  ADDR_W  absolute address for LOAD and CALL.
- `disp`  in  DISP_W  signed two's-complement displacement for BRANCH.
- `err_clr`  in  1  clears the sticky error flags.
- `pc_out`  out  ADDR_W  current PC, registered.
- `sp`  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- `stack_empty`  out  1  high when `sp`==0.
- `stack_full`  out  1  high when `sp`==STACK_DEPTH.
- `err_ovf`  out  1  sticky flag: a CALL was issued while the stack was full.
- `err_unf`  out  1  sticky flag: a RET was issued while the stack was empty.

## Operation
- Reset (`reset`=0, asynchronous) forces:
  - `pc_out`=RESET_ADDR;
  - `sp`=0, so `stack_empty`=1 and `stack_full`=0;
  - `err_ovf`=`err_unf`=0.
- Stack RAM contents are not reset.
- When `pc_en`=0, PC, stack and `sp` hold. `err_clr` still acts.
- When `pc_en`=1, behaviour depends on `pc_op`:
  - 0 INC: PC ← PC+1.
  - 1 LOAD: PC ← `target`.
  - 2 BRANCH: PC ← PC + sign_extend(`disp`). The base is the current PC, not PC+1.
  - 3 CALL:
    - If not full: push PC+1, `sp`+1, then PC ← `target`.
    - If full: no push, PC ← PC+1, and set `err_ovf`.
  - 4 RET:
    - If not empty: PC ← top entry, then `sp`−1.
    - If empty: PC ← PC+1, and set `err_unf`.
  - 5 HOLD: no change.
  - 6 and 7 are reserved and behave as HOLD.
- All PC arithmetic is modulo 2^ADDR_W:
  - INC from all-ones wraps to 0.
  - A BRANCH crossing 0 or all-ones wraps silently.
- Stack is a strict LIFO. Only one push or pop occurs per cycle.
- Errors are sticky until `err_clr`. If an error event and `err_clr` occur on the same edge, set wins.

## Timing
- All outputs are registered or decoded directly from registered `sp`; there is no combinational path from inputs to outputs.
- Latency is one cycle: the `pc_out` update is visible after the rising edge that samples `pc_en`=1.
- Back-to-back CALLs and RETs are legal on consecutive cycles.
- CALL followed immediately by RET returns to the pushed PC+1. The pushed address is readable on the next cycle; no forwarding is needed because the push and the pop happen on distinct edges.
- `stack_full`/`stack_empty` reflect `sp` after the edge. A CALL on the edge that fills the stack succeeds; the next CALL overflows.
- Reset asserted mid-sequence takes effect immediately (asynchronous). Deassertion is synchronised externally, and the first active edge after release executes normally.

## Structure
- Shared package `pc_pkg` holds:
  - op encodings `PC_INC`, `PC_LOAD`, `PC_BRANCH`, `PC_CALL`, `PC_RET`, `PC_HOLD`;
  - a 3-bit `pc_op_t` typedef.
- Sub-module `pc_stack` is a parametrised LIFO:
  - inputs `push`/`pop`/`din`;
  - outputs `top`, `sp`, `full`, `empty`;
  - storage is a flop array of STACK_DEPTH×ADDR_W.
- The top level holds the PC register, next-PC mux and error flags.

## Test plan
- Reset, then 3× INC → `pc_out`=3, `sp`=0, `stack_empty`=1.
- LOAD `target`=0x3FF, INC → `pc_out`=0x000 (wrap, ADDR_W=10). Then BRANCH `disp`=0xFE (−2) → `pc_out`=0x3FE.
- From PC=0x010: CALL 0x100, CALL 0x200, RET, RET → `pc_out` sequence 0x100, 0x200, 0x101, 0x011, with `sp` going 1, 2, 1, 0.
- Nine CALLs with STACK_DEPTH=8 → after the 8th, `stack_full`=1. The 9th gives PC+1, `sp`=8, `err_ovf`=1, which stays set until `err_clr`.
- RET on an empty stack from PC=0x020 → `pc_out`=0x021, `err_unf`=1. Then RET with `err_clr` on the same edge → `err_unf` stays 1. A lone `err_clr` next → 0.
- `pc_en`=0 with `pc_op`=CALL → no change. Asserting `reset` low mid-CALL sequence → immediate `pc_out`=RESET_ADDR, `sp`=0.
